// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/status bundle between the multi-cycle sequencer and the RV32I datapath
interface multicycle_control_if;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       Zero;
  logic       MemReady;
  logic       MemReq;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic       Illegal;

  modport master (
    input  Opcode, Funct3, Zero, MemReady,
    output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, Illegal
  );

  modport slave (
    output Opcode, Funct3, Zero, MemReady,
    input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, Illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore sequencer walking RV32I instructions through fetch/decode/execute/mem/writeback
module multicycle_control (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_BOOT, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_TRAP
  } state_t;

  state_t state_q, state_d;

  function automatic logic [1:0] imm_decode(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_ITYPE, OP_RTYPE: imm_decode = 2'b00;
      OP_STORE:                    imm_decode = 2'b01;
      OP_BRANCH:                   imm_decode = 2'b10;
      default:                     imm_decode = 2'b11;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:     state_d = S_FETCH;
      S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = (bus.Funct3 == 3'b000 || bus.Funct3 == 3'b001)
                                       ? S_BRANCH : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (bus.Opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_BOOT;
    endcase
  end

  // Async reset so an in-flight memory request is dropped the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    bus.MemReq    = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ALUOp     = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.ImmSrc    = imm_decode(bus.Opcode);
    bus.Illegal   = 1'b0;
    case (state_q)
      S_BOOT: bus.ImmSrc = 2'b00;
      S_FETCH: begin
        bus.MemReq    = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = bus.MemReady;
        bus.PCWrite   = bus.MemReady;
      end
      S_DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        bus.MemReq = 1'b1;
        bus.AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.MemReq   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.AdrSrc   = 1'b1;
      end
      S_EXECR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b10;
      end
      S_EXECI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 2'b10;
      end
      S_ALUWB: bus.RegWrite = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b01;
        bus.PCWrite = (bus.Funct3 == 3'b000) ? bus.Zero :
                      (bus.Funct3 == 3'b001) ? ~bus.Zero : 1'b0;
      end
      S_TRAP: begin
        bus.ImmSrc  = 2'b00;
        bus.Illegal = 1'b1;
      end
      default: bus.ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench driving directed instruction sequences through multicycle_control
module tb_multicycle_control;

  logic clk;
  logic rst_n;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  // {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, Illegal}
  logic [16:0] act;
  assign act = {bus.MemReq, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ResultSrc, bus.ImmSrc, bus.Illegal};

  function automatic logic [16:0] mk(input logic mreq, input logic mwr, input logic adr,
                                     input logic irw, input logic pcw, input logic rgw,
                                     input logic [1:0] asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] rs,
                                     input logic [1:0] imm, input logic ill);
    mk = {mreq, mwr, adr, irw, pcw, rgw, asa, asb, aop, rs, imm, ill};
  endfunction

  function automatic logic [16:0] e_fetch(input logic r, input logic [1:0] imm);
    e_fetch = mk(1, 0, 0, r, r, 0, 2'b00, 2'b10, 2'b00, 2'b10, imm, 0);
  endfunction
  function automatic logic [16:0] e_decode(input logic [1:0] imm);
    e_decode = mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_memadr(input logic [1:0] imm);
    e_memadr = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_memread(input logic [1:0] imm);
    e_memread = mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_memwb(input logic [1:0] imm);
    e_memwb = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, imm, 0);
  endfunction
  function automatic logic [16:0] e_memwrite(input logic [1:0] imm);
    e_memwrite = mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_execr(input logic [1:0] imm);
    e_execr = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_execi(input logic [1:0] imm);
    e_execi = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_aluwb(input logic [1:0] imm);
    e_aluwb = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_branch(input logic pcw, input logic [1:0] imm);
    e_branch = mk(0, 0, 0, 0, pcw, 0, 2'b10, 2'b00, 2'b01, 2'b00, imm, 0);
  endfunction

  localparam logic [16:0] E_ZERO = 17'h0;
  localparam logic [16:0] E_TRAP = 17'h1;

  logic [16:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  // Monitor: one scoreboard entry is consumed per cycle, sampled mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [16:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %05h expected %05h", n, act, e);
        end
      end
    end
  end

  task automatic step(input logic rn, input logic [6:0] op, input logic [2:0] f3,
                      input logic z, input logic rdy, input logic [16:0] e, input string nm);
    rst_n        = rn;
    bus.Opcode   = op;
    bus.Funct3   = f3;
    bus.Zero     = z;
    bus.MemReady = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(0, LW, 3'b010, 1, 1, E_ZERO, "reset_hold0");
    step(0, LW, 3'b010, 1, 1, E_ZERO, "reset_hold1");
    step(1, LW, 3'b010, 1, 1, E_ZERO, "boot");

    // lw: 2 fetch waits, 3 memread waits -> 10 cycles
    step(1, LW, 3'b010, 0, 0, e_fetch(0, 2'b00), "lw_fetch_wait0");
    step(1, LW, 3'b010, 0, 0, e_fetch(0, 2'b00), "lw_fetch_wait1");
    step(1, LW, 3'b010, 0, 1, e_fetch(1, 2'b00), "lw_fetch_rdy");
    step(1, LW, 3'b010, 0, 1, e_decode(2'b00),   "lw_decode_spurious_rdy");
    step(1, LW, 3'b010, 0, 0, e_memadr(2'b00),   "lw_memadr");
    step(1, LW, 3'b010, 0, 0, e_memread(2'b00),  "lw_memread_wait0");
    step(1, LW, 3'b010, 0, 0, e_memread(2'b00),  "lw_memread_wait1");
    step(1, LW, 3'b010, 0, 0, e_memread(2'b00),  "lw_memread_wait2");
    step(1, LW, 3'b010, 0, 1, e_memread(2'b00),  "lw_memread_rdy");
    step(1, LW, 3'b010, 0, 0, e_memwb(2'b00),    "lw_memwb");

    step(1, SW, 3'b010, 0, 1, e_fetch(1, 2'b01),  "sw_fetch");
    step(1, SW, 3'b010, 0, 1, e_decode(2'b01),    "sw_decode");
    step(1, SW, 3'b010, 0, 1, e_memadr(2'b01),    "sw_memadr");
    step(1, SW, 3'b010, 0, 1, e_memwrite(2'b01),  "sw_memwrite");

    step(1, RT, 3'b000, 0, 1, e_fetch(1, 2'b00), "r_fetch");
    step(1, RT, 3'b000, 0, 1, e_decode(2'b00),   "r_decode");
    step(1, RT, 3'b000, 0, 1, e_execr(2'b00),    "r_execr");
    step(1, RT, 3'b000, 0, 1, e_aluwb(2'b00),    "r_aluwb");

    step(1, IT, 3'b000, 0, 1, e_fetch(1, 2'b00), "i_fetch");
    step(1, IT, 3'b000, 0, 1, e_decode(2'b00),   "i_decode");
    step(1, IT, 3'b000, 0, 1, e_execi(2'b00),    "i_execi");
    step(1, IT, 3'b000, 0, 1, e_aluwb(2'b00),    "i_aluwb");

    step(1, BR, 3'b000, 1, 1, e_fetch(1, 2'b10),  "beq_fetch");
    step(1, BR, 3'b000, 1, 1, e_decode(2'b10),    "beq_decode");
    step(1, BR, 3'b000, 1, 1, e_branch(1, 2'b10), "beq_z1_taken");

    step(1, BR, 3'b001, 1, 1, e_fetch(1, 2'b10),  "bne_fetch");
    step(1, BR, 3'b001, 1, 1, e_decode(2'b10),    "bne_decode");
    step(1, BR, 3'b001, 1, 1, e_branch(0, 2'b10), "bne_z1_not_taken");

    step(1, BR, 3'b001, 0, 1, e_fetch(1, 2'b10),  "bne2_fetch");
    step(1, BR, 3'b001, 0, 1, e_decode(2'b10),    "bne2_decode");
    step(1, BR, 3'b001, 0, 1, e_branch(1, 2'b10), "bne_z0_taken");

    step(1, JAL, 3'b000, 0, 1, e_fetch(1, 2'b11), "jal_fetch");
    step(1, JAL, 3'b000, 0, 1, e_decode(2'b11),   "jal_decode");
    for (int i = 0; i < 20; i++)
      step(1, JAL, 3'(i), 1'(i), 1'(i >> 1), E_TRAP, "trap_hold");
    step(0, JAL, 3'b000, 0, 1, E_ZERO, "trap_reset_clears");
    step(1, LW, 3'b000, 0, 1, E_ZERO, "trap_boot");
    step(1, LW, 3'b000, 0, 1, e_fetch(1, 2'b00), "after_trap_fetch");
    step(1, LW, 3'b000, 0, 1, e_decode(2'b00),   "after_trap_decode");
    step(1, LW, 3'b000, 0, 1, e_memadr(2'b00),   "after_trap_memadr");
    step(1, LW, 3'b000, 0, 1, e_memread(2'b00),  "after_trap_memread");
    step(1, LW, 3'b000, 0, 1, e_memwb(2'b00),    "after_trap_memwb");

    // branch opcode with unsupported funct3 traps
    step(1, BR, 3'b100, 0, 1, e_fetch(1, 2'b10), "blt_fetch");
    step(1, BR, 3'b100, 0, 1, e_decode(2'b10),   "blt_decode");
    step(1, BR, 3'b100, 0, 1, E_TRAP,            "blt_trap");
    step(0, BR, 3'b100, 0, 1, E_ZERO,            "blt_reset");
    step(1, SW, 3'b000, 0, 1, E_ZERO,            "blt_boot");

    // reset asserted mid-MEMWRITE while waiting
    step(1, SW, 3'b010, 0, 1, e_fetch(1, 2'b01),  "swr_fetch");
    step(1, SW, 3'b010, 0, 0, e_decode(2'b01),    "swr_decode");
    step(1, SW, 3'b010, 0, 0, e_memadr(2'b01),    "swr_memadr");
    step(1, SW, 3'b010, 0, 0, e_memwrite(2'b01),  "swr_memwrite_wait");
    step(0, SW, 3'b010, 0, 0, E_ZERO,             "swr_reset_mid_access");
    step(0, SW, 3'b010, 0, 1, E_ZERO,             "swr_reset_hold");
    step(1, RT, 3'b000, 0, 1, E_ZERO,             "swr_boot");
    step(1, RT, 3'b000, 0, 0, e_fetch(0, 2'b00),  "swr_refetch_wait");
    step(1, RT, 3'b000, 0, 1, e_fetch(1, 2'b00),  "swr_refetch_rdy");
    step(1, RT, 3'b000, 0, 1, e_decode(2'b00),    "swr_redecode");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style sequencer for the multi-cycle RV32I datapath. It walks each instruction through fetch, decode, execute, memory and writeback states and drives every datapath select and enable, including the `ImmSrc` code that configures the sign extender. Memory accesses use a request/ready handshake with wait states. It supports lw, sw, R-type ALU, I-type ALU, beq and bne; any other encoding traps.

## Interface
- No parameters.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Opcode`  in  7  instruction bits [6:0], taken from the instruction register.
- `Funct3`  in  3  instruction bits [14:12].
- `Zero`  in  1  ALU zero flag.
- `MemReady`  in  1  memory completes the current access this cycle.
- `MemReq`  out  1  memory access request.
- `MemWrite`  out  1  memory access is a write.
- `AdrSrc`  out  1  0 = PC, 1 = ALUOut.
- `IRWrite`  out  1  load the instruction register and OldPC.
- `PCWrite`  out  1  load PC from the result bus.
- `RegWrite`  out  1  register-file write enable.
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = rs1 register.
- `ALUSrcB`  out  2  00 = rs2 register, 01 = immediate, 10 = constant 4.
- `ALUOp`  out  2  00 = add, 01 = subtract, 10 = decode from funct fields.
- `ResultSrc`  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result.
- `ImmSrc`  out  2  00 = I-type, 01 = S-type, 10 = B-type, 11 = invalid.
- `Illegal`  out  1  sticky trap flag.

## Operation
- **States:** BOOT, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, TRAP.
- **Outputs:** decoded from the state register only, except where gated by `MemReady` or `Zero`. Any output not listed for a state is 0.
- **BOOT:** all outputs 0. Goes to FETCH on the next edge.
- **FETCH:** `MemReq`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10.
  - `IRWrite` = `PCWrite` = `MemReady`.
  - Stays in FETCH until `MemReady`, then goes to DECODE.
- **DECODE:** `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00. This precomputes the branch target into ALUOut. Next state by `Opcode`:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 with `Funct3` 000 or 001 → BRANCH.
  - Anything else → TRAP.
- **MEMADR:** `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00. Goes to MEMREAD for a load, MEMWRITE for a store.
- **MEMREAD:** `MemReq`=1, `AdrSrc`=1. Holds until `MemReady`, then goes to MEMWB.
- **MEMWB:** `ResultSrc`=01, `RegWrite`=1. Goes to FETCH.
- **MEMWRITE:** `MemReq`=1, `MemWrite`=1, `AdrSrc`=1. Holds until `MemReady`, then goes to FETCH.
- **EXECR:** `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10. Goes to ALUWB.
- **EXECI:** `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10. Goes to ALUWB.
- **ALUWB:** `ResultSrc`=00, `RegWrite`=1. Goes to FETCH.
- **BRANCH:** `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00.
  - `PCWrite` = `Zero` when `Funct3`=000, `PCWrite` = !`Zero` when `Funct3`=001.
  - Goes to FETCH.
- **TRAP:** all outputs 0 except `Illegal`=1. Absorbing; only reset exits.
- **`ImmSrc`:** decoded combinationally from `Opcode` in every state except BOOT and TRAP.
  - 0000011 or 0010011 → 00.
  - 0100011 → 01.
  - 1100011 → 10.
  - 0110011 → 00.
  - Otherwise → 11.
  - BOOT and TRAP drive 00.

## Timing
- **Reset:** asserting `rst_n` low forces BOOT immediately, at any point including mid-access. All outputs go to 0 at once, including `Illegal`. An outstanding memory request is abandoned without waiting for `MemReady`.
- **First fetch:** `MemReq` first rises one cycle after `rst_n` deasserts (the BOOT cycle).
- **Minimum cycle counts, with `MemReady` high on first request:**
  - lw 5 (FETCH, DECODE, MEMADR, MEMREAD, MEMWB).
  - sw 4.
  - R-type 4.
  - I-type 4.
  - beq/bne 3.
- **Wait states:** each cycle of `MemReady` low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- **Handshake:** `MemReq`, `AdrSrc` and `MemWrite` stay stable while waiting. `IRWrite` and `PCWrite` pulse in the `MemReady` cycle only.
- **Spurious ready:** `MemReady` outside the memory states is ignored.
- **Branch decision:** `Zero` is sampled only in BRANCH. `PCWrite` is a single-cycle pulse.

## Test plan
- **Reset:** hold `rst_n` low, then release. All outputs are 0 during reset and in BOOT. FETCH follows on the next cycle with `MemReq`=1, `ALUSrcB`=10.
- **Load with wait:** Opcode 0000011, `MemReady` low for 2 cycles in FETCH and 3 in MEMREAD. Total 10 cycles. `RegWrite`=1 only in MEMWB with `ResultSrc`=01. `ImmSrc`=00.
- **Store:** Opcode 0100011, `MemReady` always high. 4 cycles. `MemWrite`=1 only in MEMWRITE. `ImmSrc`=01. `RegWrite` never asserted.
- **Branches:** beq with `Zero`=1 gives a `PCWrite` pulse in BRANCH. bne with `Zero`=1 gives none. Both take 3 cycles with `ImmSrc`=10 and `ALUOp`=01.
- **Illegal opcode:** Opcode 1101111 enters TRAP after DECODE. `Illegal`=1 and stays high for 20 cycles with all other outputs 0. Reset clears it.
- **Reset mid-access:** assert `rst_n` low during MEMWRITE while `MemReady` is low. `MemWrite` and `MemReq` drop immediately. Normal fetch resumes after release.
